// File: rtl/equiv_pkg.sv
// Shared widths, LFSR tap positions and FSM encoding for the equivalence stimulus driver.
package equiv_pkg;
   localparam int W0     = 26;
   localparam int W1     = 25;
   localparam int W2     = 15;
   localparam int W3     = 6;
   localparam int WY     = 91;
   localparam int STIM_W = W0 + W1 + W2 + W3;

   // Tap positions are 1-based, in the usual LFSR table notation.
   localparam int TAP_A = 80;
   localparam int TAP_B = 79;
   localparam int TAP_C = 43;
   localparam int TAP_D = 42;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;
endpackage

// File: rtl/equiv_lfsr.sv
// Fibonacci XNOR LFSR with seed load and an all-ones lock-up guard.
// Exposes the post-edge state so the caller can register it in step with the LFSR.
module equiv_lfsr
   import equiv_pkg::*;
#(
   parameter int                LFSR_W   = 80,
   parameter logic [LFSR_W-1:0] DEF_SEED = LFSR_W'(1),
   parameter int                OUT_W    = STIM_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [LFSR_W-1:0] seed_i,
   input  logic              step_i,
   output logic [OUT_W-1:0]  state_nxt_o
);
   logic [LFSR_W-1:0] state_q, state_d;
   logic              fb;

   always_comb begin
      fb      = ~(state_q[TAP_A-1] ^ state_q[TAP_B-1] ^ state_q[TAP_C-1] ^ state_q[TAP_D-1]);
      state_d = state_q;
      if (load_i) begin
         state_d = (&seed_i) ? DEF_SEED : seed_i;
      end else if (step_i) begin
         state_d = {state_q[LFSR_W-2:0], fb};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= '1;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_nxt_o = state_d[OUT_W-1:0];
endmodule

// File: rtl/equiv_stim_driver.sv
// Drives LFSR vectors into a DUT pair and compares y_1/y_2 CMP_DELAY cycles later.
// Define EQUIV_VEC_CAPTURE_EN to add the fail_vec/fail_y1/fail_y2 capture outputs.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one vector per cycle, token pushed into compare pipe
//   DRAIN | stimulus held, waiting for in-flight tokens
//   DONE  | verdict valid
module equiv_stim_driver
   import equiv_pkg::*;
#(
   parameter int                LFSR_W    = 80,
   parameter int                CNT_W     = 16,
   parameter int                CMP_DELAY = 1,
   parameter logic [LFSR_W-1:0] DEF_SEED  = LFSR_W'(1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LFSR_W-1:0]    seed_in,
   input  logic [CNT_W-1:0]     num_vec,
   output logic signed [W0-1:0] wire0,
   output logic signed [W1-1:0] wire1,
   output logic [W2-1:0]        wire2,
   output logic signed [W3-1:0] wire3,
   input  logic [WY-1:0]        y_1,
   input  logic [WY-1:0]        y_2,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_W-1:0]     fail_idx
`ifdef EQUIV_VEC_CAPTURE_EN
   ,
   output logic [STIM_W-1:0]    fail_vec,
   output logic [WY-1:0]        fail_y1,
   output logic [WY-1:0]        fail_y2
`endif
);
   localparam int PD = (CMP_DELAY == 0) ? 1 : CMP_DELAY;

   state_e            state_q, state_d;
   logic [STIM_W-1:0] stim_q, stim_nxt;
   logic [CNT_W-1:0]  num_q, vec_cnt_q, fail_idx_q;
   logic              pass_q;
   logic [PD-1:0]     pv_q;
   logic [CNT_W-1:0]  pidx_q [PD];
   logic              accept, push, last, lfsr_step;
   logic              ex_v, mism, drain_busy;
   logic [CNT_W-1:0]  ex_idx;

   assign accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
   assign push   = (state_q == ST_RUN);
   assign last   = (vec_cnt_q == num_q - CNT_W'(1));
   assign busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done   = (state_q == ST_DONE);

   equiv_lfsr #(
      .LFSR_W   (LFSR_W),
      .DEF_SEED (DEF_SEED),
      .OUT_W    (STIM_W)
   ) u_lfsr (
      .clk         (clk),
      .rst         (rst),
      .load_i      (accept),
      .seed_i      (seed_in),
      .step_i      (lfsr_step),
      .state_nxt_o (stim_nxt)
   );

   // With zero latency the vector being driven right now is the one compared.
   always_comb begin
      if (CMP_DELAY == 0) begin
         ex_v   = push;
         ex_idx = vec_cnt_q;
      end else begin
         ex_v   = pv_q[PD-1];
         ex_idx = pidx_q[PD-1];
      end
      drain_busy = 1'b0;
      for (int i = 0; i < PD - 1; i++) begin
         drain_busy = drain_busy | pv_q[i];
      end
      mism = busy && ex_v && (y_1 !== y_2);
   end

   always_comb begin
      state_d   = state_q;
      lfsr_step = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (mism)      state_d = ST_DONE;
            else if (last) state_d = (CMP_DELAY == 0) ? ST_DONE : ST_DRAIN;
            else           lfsr_step = 1'b1;
         end
         ST_DRAIN: begin
            if (mism || !drain_busy) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         stim_q     <= '0;
         num_q      <= '0;
         vec_cnt_q  <= '0;
         pass_q     <= 1'b0;
         fail_idx_q <= '0;
         pv_q       <= '0;
         for (int i = 0; i < PD; i++) pidx_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if ((accept && (num_vec != '0)) || lfsr_step) stim_q <= stim_nxt;
         if (accept) begin
            num_q      <= num_vec;
            vec_cnt_q  <= '0;
            pv_q       <= '0;
            pass_q     <= (num_vec == '0);
            fail_idx_q <= '0;
         end else begin
            if (lfsr_step) vec_cnt_q <= vec_cnt_q + CNT_W'(1);
            for (int i = PD - 1; i > 0; i--) begin
               pv_q[i]   <= pv_q[i-1];
               pidx_q[i] <= pidx_q[i-1];
            end
            pv_q[0]   <= push;
            pidx_q[0] <= vec_cnt_q;
            if (mism)                                fail_idx_q <= ex_idx;
            else if (busy && (state_d == ST_DONE))   pass_q     <= 1'b1;
         end
      end
   end

   assign wire0    = stim_q[W0-1:0];
   assign wire1    = stim_q[W0+W1-1:W0];
   assign wire2    = stim_q[W0+W1+W2-1:W0+W1];
   assign wire3    = stim_q[STIM_W-1:W0+W1+W2];
   assign pass     = pass_q;
   assign fail_idx = fail_idx_q;

`ifdef EQUIV_VEC_CAPTURE_EN
   logic [STIM_W-1:0] pstim_q [PD];
   logic [STIM_W-1:0] ex_stim;
   logic [STIM_W-1:0] fail_vec_q;
   logic [WY-1:0]     fail_y1_q, fail_y2_q;

   assign ex_stim = (CMP_DELAY == 0) ? stim_q : pstim_q[PD-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PD; i++) pstim_q[i] <= '0;
         fail_vec_q <= '0;
         fail_y1_q  <= '0;
         fail_y2_q  <= '0;
      end else begin
         for (int i = PD - 1; i > 0; i--) pstim_q[i] <= pstim_q[i-1];
         pstim_q[0] <= stim_q;
         if (mism) begin
            fail_vec_q <= ex_stim;
            fail_y1_q  <= y_1;
            fail_y2_q  <= y_2;
         end
      end
   end

   assign fail_vec = fail_vec_q;
   assign fail_y1  = fail_y1_q;
   assign fail_y2  = fail_y2_q;
`endif
endmodule

// File: tb/tb_equiv_stim_driver.sv
// Directed bench for equiv_stim_driver with a one-cycle-latency loopback pair.
module tb_equiv_stim_driver;
   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [79:0]        seed_in;
   logic [15:0]        num_vec;
   logic signed [25:0] wire0;
   logic signed [24:0] wire1;
   logic [14:0]        wire2;
   logic signed [5:0]  wire3;
   logic [90:0]        y_1, y_2;
   logic               busy, done, pass;
   logic [15:0]        fail_idx;
`ifdef EQUIV_VEC_CAPTURE_EN
   logic [71:0]        fail_vec;
   logic [90:0]        fail_y1, fail_y2;
`endif

   int total = 0;
   int bad   = 0;

   logic [90:0] y_q = '0;
   logic        inj_en = 1'b0;
   logic [71:0] inj_vec = '0;

   always #5 clk = ~clk;

   // DUT pair model: response appears one cycle after the stimulus.
   always @(posedge clk) y_q <= {19'd0, wire3, wire2, wire1, wire0};
   assign y_1 = y_q;
   assign y_2 = y_q ^ ((inj_en && (y_q[71:0] == inj_vec)) ? 91'd1 : 91'd0);

   equiv_stim_driver dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .seed_in  (seed_in),
      .num_vec  (num_vec),
      .wire0    (wire0),
      .wire1    (wire1),
      .wire2    (wire2),
      .wire3    (wire3),
      .y_1      (y_1),
      .y_2      (y_2),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .fail_idx (fail_idx)
`ifdef EQUIV_VEC_CAPTURE_EN
      ,
      .fail_vec (fail_vec),
      .fail_y1  (fail_y1),
      .fail_y2  (fail_y2)
`endif
   );

   typedef struct {
      logic [79:0] seed;
      logic [15:0] num;
      int          inj;
      int          poke;
      logic        exp_pass;
      logic [15:0] exp_fidx;
      int          exp_busy;
   } vec_t;

   function automatic logic [79:0] lstep(input logic [79:0] s);
      return {s[78:0], ~(s[79] ^ s[78] ^ s[42] ^ s[41])};
   endfunction

   function automatic logic [71:0] stim_now();
      return {wire3, wire2, wire1, wire0};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int id);
      logic [79:0] s0, cur;
      logic [71:0] pre;
      int          b, bad_at;
      s0 = (&v.seed) ? 80'h1 : v.seed;
      cur = s0;
      for (int k = 0; k < v.inj; k++) cur = lstep(cur);
      inj_vec = cur[71:0];
      inj_en  = (v.inj >= 0);
      pre = stim_now();
      @(negedge clk);
      seed_in = v.seed;
      num_vec = v.num;
      start   = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      b      = 0;
      bad_at = -1;
      cur    = s0;
      while (busy === 1'b1 && b < 2500) begin
         if (stim_now() !== cur[71:0] && bad_at < 0) bad_at = b;
         start = (b == v.poke);
         if (b == v.poke) begin
            seed_in = 80'hFFFF;
            num_vec = 16'd3;
         end
         b++;
         if (b < int'(v.num)) cur = lstep(cur);
         @(negedge clk);
      end
      start = 1'b0;
      chk($sformatf("run%0d busy_cycles", id), 128'(b), 128'(v.exp_busy));
      chk($sformatf("run%0d done", id), 128'(done), 128'(1));
      chk($sformatf("run%0d pass", id), 128'(pass), 128'(v.exp_pass));
      chk($sformatf("run%0d fail_idx", id), 128'(fail_idx), 128'(v.exp_fidx));
      chk($sformatf("run%0d stim_stream_first_bad", id), 128'(bad_at), 128'(-1));
      if (v.num == 16'd0) chk($sformatf("run%0d wires_held", id), 128'(stim_now()), 128'(pre));
`ifdef EQUIV_VEC_CAPTURE_EN
      if (!v.exp_pass) begin
         chk($sformatf("run%0d fail_vec", id), 128'(fail_vec), 128'(inj_vec));
         chk($sformatf("run%0d fail_y_diff", id), 128'(fail_y1 ^ fail_y2), 128'(1));
      end
`endif
      inj_en = 1'b0;
      if (busy) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[9];
      vec_t pk;
      tbl[0] = '{80'h5,    16'd1000, -1, -1, 1'b1, 16'd0,  1001};
      tbl[1] = '{80'h5,    16'd1000, 37, -1, 1'b0, 16'd37, 39};
      tbl[2] = '{80'hABC,  16'd5,    -1, -1, 1'b1, 16'd0,  6};
      tbl[3] = '{80'hABC,  16'd5,    -1, -1, 1'b1, 16'd0,  6};
      tbl[4] = '{80'h1234, 16'd0,    -1, -1, 1'b1, 16'd0,  0};
      tbl[5] = '{'1,       16'd3,    -1, -1, 1'b1, 16'd0,  4};
      tbl[6] = '{80'h77,   16'd10,    9, -1, 1'b0, 16'd9,  11};
      tbl[7] = '{80'h99,   16'd10,    0, -1, 1'b0, 16'd0,  2};
      tbl[8] = '{80'hDEAD, 16'd1,    -1, -1, 1'b1, 16'd0,  2};

      rst = 1'b1;
      start = 1'b0;
      seed_in = '0;
      num_vec = '0;
      repeat (2) @(negedge clk);
      chk("reset busy", 128'(busy), 128'(0));
      chk("reset done", 128'(done), 128'(0));
      chk("reset pass", 128'(pass), 128'(0));
      chk("reset fail_idx", 128'(fail_idx), 128'(0));
      chk("reset wires", 128'(stim_now()), 128'(0));
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

      // Asynchronous reset in the middle of a long run.
      @(negedge clk);
      seed_in = 80'h5;
      num_vec = 16'd1000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (500) @(negedge clk);
      chk("midrun busy_before_rst", 128'(busy), 128'(1));
      #2 rst = 1'b1;
      #1;
      chk("midrun rst busy", 128'(busy), 128'(0));
      chk("midrun rst done", 128'(done), 128'(0));
      chk("midrun rst pass", 128'(pass), 128'(0));
      chk("midrun rst fail_idx", 128'(fail_idx), 128'(0));
      chk("midrun rst wires", 128'(stim_now()), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Full run after reset, with a stray start pulsed while busy.
      pk = '{80'h5, 16'd20, -1, 5, 1'b1, 16'd0, 21};
      run_vec(pk, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
